gcd_job_sequencer: RTL and testbench

- Host-side driver of the GCD core control/datapath interface: accepts operand pairs on a valid/ready stream, runs one core job per pair, and returns the result on a valid/ready stream.
- Owns the core's reset and enable. Holds the core in reset between jobs, because the core's controller stays latched in its FINISH state.
- Resolves zero operands locally, bounds each job with a timeout, and reports the job cycle count.

---
 rtl/gcd_seq_pkg.sv | 19 +
 rtl/gcd_job_sequencer_timer.sv | 47 ++++
 rtl/gcd_job_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_seq_pkg.sv
// Shared types, default parameters and width helper for the GCD job sequencer.
package gcd_seq_pkg;

  // Sequencer phases: waiting for a pair, core running, result on offer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Bits needed to hold every count from 0 up to and including the timeout.
  function automatic int cycle_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/gcd_job_sequencer_timer.sv
// Saturating job-cycle counter. A clear together with an enable loads 1, so
// the first counted cycle already reads 1; the count stops at LIMIT.
module gcd_seq_timer
  import gcd_seq_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES,
  parameter int W     = cycle_width(LIMIT)
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] value_o,
  output logic         at_limit_o
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] value_d, value_q;

  // Next count: clear has priority, otherwise step until the limit is reached.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    value_d = value_q;
    if (clear_i) begin
      value_d = en_i ? W'(1) : '0;
    end else if (en_i && (value_q != LIMIT_V)) begin
      value_d = value_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!nreset_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o    = value_q;
  assign at_limit_o = (value_q == LIMIT_V);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Host-side driver for the GCD core: takes operand pairs, runs one core job
// per pair (or resolves zero operands locally), bounds the job with a
// timeout and returns gcd, timeout flag and cycle count. The core is held in
// reset whenever no job is running, since its controller latches in FINISH.
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CYCLE_W        = cycle_width(TIMEOUT_CYCLES)
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_gcd_o,
  output logic                  res_timeout_o,
  output logic [CYCLE_W-1:0]    res_cycles_o,
  output logic                  busy_o,
  output logic                  core_nreset_o,
  output logic                  core_enable_o,
  output logic [DATA_WIDTH-1:0] core_a_o,
  output logic [DATA_WIDTH-1:0] core_b_o,
  input  logic                  core_flag_init_i,
  input  logic                  core_flag_compute_i,
  input  logic                  core_flag_finish_i,
  input  logic [DATA_WIDTH-1:0] core_result_i
);

  seq_state_e            state_d, state_q;
  logic                  res_valid_d, res_valid_q;
  logic [DATA_WIDTH-1:0] res_gcd_d, res_gcd_q;
  logic                  res_timeout_d, res_timeout_q;
  logic [CYCLE_W-1:0]    res_cycles_d, res_cycles_q;
  logic                  core_nreset_d, core_nreset_q;
  logic                  core_enable_d, core_enable_q;
  logic [DATA_WIDTH-1:0] core_a_d, core_a_q;
  logic [DATA_WIDTH-1:0] core_b_d, core_b_q;

  logic                  timer_clear;
  logic                  timer_en;
  logic [CYCLE_W-1:0]    timer_value;
  logic                  timer_at_limit;

  // The core's INIT/COMPUTE flags are informational only.
  logic                  unused_core_flags;
  assign unused_core_flags = core_flag_init_i ^ core_flag_compute_i;

  gcd_seq_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CYCLE_W)
  ) u_timer (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .clear_i    (timer_clear),
    .en_i       (timer_en),
    .value_o    (timer_value),
    .at_limit_o (timer_at_limit)
  );

  // Job flow: accept or bypass in IDLE, watch finish/timeout in RUN, offer
  // the result in DONE until the consumer takes it.
  always_comb begin
    state_d       = state_q;
    res_valid_d   = res_valid_q;
    res_gcd_d     = res_gcd_q;
    res_timeout_d = res_timeout_q;
    res_cycles_d  = res_cycles_q;
    core_nreset_d = core_nreset_q;
    core_enable_d = core_enable_q;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        core_nreset_d = 1'b0;
        core_enable_d = 1'b0;
        if (op_valid_i) begin
          if ((op_a_i != '0) && (op_b_i != '0)) begin
            core_a_d      = op_a_i;
            core_b_d      = op_b_i;
            core_nreset_d = 1'b1;
            core_enable_d = 1'b1;
            timer_clear   = 1'b1;
            timer_en      = 1'b1;
            state_d       = S_RUN;
          end else begin
            // gcd(x, 0) = x, and the OR yields 0 when both are zero.
            res_gcd_d     = op_a_i | op_b_i;
            res_cycles_d  = '0;
            res_timeout_d = 1'b0;
            res_valid_d   = 1'b1;
            state_d       = S_DONE;
          end
        end
      end

      S_RUN: begin
        timer_en = 1'b1;
        // Finish is checked first so it wins over a simultaneous timeout.
        if (core_flag_finish_i) begin
          res_gcd_d     = core_result_i;
          res_cycles_d  = timer_value;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          core_nreset_d = 1'b0;
          core_enable_d = 1'b0;
          state_d       = S_DONE;
        end else if (timer_at_limit) begin
          res_gcd_d     = '0;
          res_cycles_d  = CYCLE_W'(TIMEOUT_CYCLES);
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          core_nreset_d = 1'b0;
          core_enable_d = 1'b0;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All sequencer state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q       <= S_IDLE;
      res_valid_q   <= 1'b0;
      res_gcd_q     <= '0;
      res_timeout_q <= 1'b0;
      res_cycles_q  <= '0;
      core_nreset_q <= 1'b0;
      core_enable_q <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
    end else begin
      state_q       <= state_d;
      res_valid_q   <= res_valid_d;
      res_gcd_q     <= res_gcd_d;
      res_timeout_q <= res_timeout_d;
      res_cycles_q  <= res_cycles_d;
      core_nreset_q <= core_nreset_d;
      core_enable_q <= core_enable_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
    end
  end

  assign op_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign res_valid_o   = res_valid_q;
  assign res_gcd_o     = res_gcd_q;
  assign res_timeout_o = res_timeout_q;
  assign res_cycles_o  = res_cycles_q;
  assign core_nreset_o = core_nreset_q;
  assign core_enable_o = core_enable_q;
  assign core_a_o      = core_a_q;
  assign core_b_o      = core_b_q;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer: a behavioural GCD core with a
// programmable finish latency, directed scenarios and randomized jobs, all
// checked against expectations computed from plain arithmetic.
module tb_gcd_job_sequencer;

  localparam int DW = 16;
  localparam int T  = 16;
  localparam int CW = $clog2(T + 1);

  logic          clk;
  logic          nreset;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_gcd;
  logic          res_timeout;
  logic [CW-1:0] res_cycles;
  logic          busy;
  logic          core_nreset, core_enable;
  logic [DW-1:0] core_a, core_b;
  logic          core_init, core_compute, core_finish;
  logic [DW-1:0] core_result;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Finish latency of the core model: 0 means the core never finishes.
  int            m_lat = 0;
  logic [7:0]    m_cnt;

  gcd_job_sequencer #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T),
    .CYCLE_W        (CW)
  ) dut (
    .clk_i               (clk),
    .nreset_i            (nreset),
    .op_valid_i          (op_valid),
    .op_ready_o          (op_ready),
    .op_a_i              (op_a),
    .op_b_i              (op_b),
    .res_valid_o         (res_valid),
    .res_ready_i         (res_ready),
    .res_gcd_o           (res_gcd),
    .res_timeout_o       (res_timeout),
    .res_cycles_o        (res_cycles),
    .busy_o              (busy),
    .core_nreset_o       (core_nreset),
    .core_enable_o       (core_enable),
    .core_a_o            (core_a),
    .core_b_o            (core_b),
    .core_flag_init_i    (core_init),
    .core_flag_compute_i (core_compute),
    .core_flag_finish_i  (core_finish),
    .core_result_i       (core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: counts cycles out of reset; finish rises in the m_lat-th
  // cycle after release and the result is only meaningful while finish is high.
  always @(posedge clk) begin
    if (!core_nreset) m_cnt <= 8'd0;
    else if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
  end

  assign core_finish  = core_nreset && (m_lat != 0) && (int'(m_cnt) >= m_lat - 1);
  assign core_init    = core_nreset && (m_cnt == 8'd0) && !core_finish;
  assign core_compute = core_nreset && (m_cnt != 8'd0) && !core_finish;
  assign core_result  = core_finish ? ref_gcd(core_a, core_b) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"},   32'(res_valid),   32'd0);
    check({tag, "_res_gcd"},     32'(res_gcd),     32'd0);
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_res_cycles"},  32'(res_cycles),  32'd0);
    check({tag, "_core_nreset"}, 32'(core_nreset), 32'd0);
    check({tag, "_core_enable"}, 32'(core_enable), 32'd0);
    check({tag, "_core_ab"},     {core_a, core_b}, 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_op_ready"},    32'(op_ready),    32'd1);
  endtask

  // One complete job: offer (a,b), follow it through RUN, hold the result
  // for 'hold' cycles with a distracting op_valid, then take it.
  task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int lat, input int hold);
    logic [DW-1:0] exp_gcd;
    logic          exp_to;
    int            exp_cyc;
    bit            bypass;
    bit            bad_run;
    bit            bad_hold;
    int            n;

    bypass = (a == 0) || (b == 0);
    if (bypass) begin
      exp_gcd = a | b; exp_to = 1'b0; exp_cyc = 0;
    end else if (lat != 0 && lat <= T) begin
      exp_gcd = ref_gcd(a, b); exp_to = 1'b0; exp_cyc = lat;
    end else begin
      exp_gcd = '0; exp_to = 1'b1; exp_cyc = T;
    end

    check("idle_ready", 32'(op_ready), 32'd1);
    m_lat    = lat;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    op_a     = DW'($urandom);
    op_b     = DW'($urandom);

    n = 0;
    bad_run = 1'b0;
    while (res_valid !== 1'b1 && n < 4 * T) begin
      if (core_nreset !== 1'b1 || core_enable !== 1'b1 || op_ready !== 1'b0 || busy !== 1'b1)
        bad_run = 1'b1;
      @(negedge clk);
      n++;
    end
    check("run_cycles",   32'(n),           32'(exp_cyc));
    check("run_controls", 32'(bad_run),     32'd0);
    check("res_gcd",      32'(res_gcd),     32'(exp_gcd));
    check("res_timeout",  32'(res_timeout), 32'(exp_to));
    check("res_cycles",   32'(res_cycles),  32'(exp_cyc));
    check("done_core_nreset", 32'(core_nreset), 32'd0);
    check("done_core_enable", 32'(core_enable), 32'd0);
    check("done_op_ready",    32'(op_ready),    32'd0);
    if (!bypass) check("core_ab_hold", {core_a, core_b}, {a, b});

    bad_hold = 1'b0;
    op_valid = 1'b1;
    op_a     = 16'd77;
    op_b     = 16'd11;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_gcd !== exp_gcd || res_timeout !== exp_to ||
          res_cycles !== CW'(exp_cyc) || busy !== 1'b1 || core_nreset !== 1'b0)
        bad_hold = 1'b1;
    end
    op_valid = 1'b0;
    check("hold_stable", 32'(bad_hold), 32'd0);

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("ack_res_valid",   32'(res_valid),   32'd0);
    check("ack_idle",        32'(op_ready),    32'd1);
    check("ack_core_nreset", 32'(core_nreset), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    logic [DW-1:0] ra, rb;

    nreset    = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;
    @(negedge clk);

    // Basic core job, finish after 5 cycles.
    run_job(16'd48, 16'd18, 5, 0);

    // Zero operands are resolved without the core.
    run_job(16'd0,  16'd35, 5, 0);
    run_job(16'd0,  16'd0,  5, 1);
    run_job(16'd35, 16'd0,  5, 0);

    // Core never finishes: timeout after T cycles.
    run_job(16'd100, 16'd75, 0, 0);

    // Consumer stalls for 5 cycles.
    run_job(16'd270, 16'd192, 4, 5);

    // Finish exactly at the timeout boundary wins; one past it times out.
    run_job(16'd91, 16'd65, T, 0);
    run_job(16'd91, 16'd65, T + 1, 0);
    run_job(16'd7, 16'd13, 1, 0);

    // Reset mid-RUN abandons the job silently.
    m_lat    = 0;
    op_a     = 16'd100;
    op_b     = 16'd75;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    nreset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    nreset = 1'b1;
    quiet  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || core_nreset !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("midrst_quiet", 32'(quiet), 32'd1);
    run_job(16'd12, 16'd8, 3, 1);

    // Randomized jobs, including zero operands and timeouts.
    repeat (25) begin
      ra = ($urandom_range(0, 5) == 0) ? 16'd0 : DW'($urandom_range(1, 65535));
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : DW'($urandom_range(1, 65535));
      run_job(ra, rb, $urandom_range(0, T + 4), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
